// File: rtl/hc_subtractor.sv
// hc_subtractor: 16-bit pipelined subtractor, Diff = A - B - Bin, built as
// A + ~B + ~Bin through a Han-Carlson parallel-prefix carry network.
//
// Pipeline (one register boundary per step, 7 enabled edges of latency):
//   s1  pre-processing: g/p/x from A and ~B, Cin = ~Bin folded into g[0]
//   s2  odd-pair combine: odd i takes (g,p)[i] o (g,p)[i-1]
//   s3  Kogge-Stone on odd positions, odd-span 1 (bit distance 2)
//   s4  Kogge-Stone on odd positions, odd-span 2 (bit distance 4)
//   s5  Kogge-Stone on odd positions, odd-span 4 (bit distance 8)
//   s6  even-position fix-up: even i takes g[i] | p[i] & G[i-1:0]
//   out difference/borrow output register (plus flags when enabled)
//
// Flow control: there is no ready. On a rising edge with en=1 every stage
// advances by one and in_valid/A/B/Bin are sampled into s1; on an edge with
// en=0 every register holds and the inputs are ignored. out_valid alone
// qualifies Diff/Bout; data registers load on every enabled edge whether or
// not their valid flag is set.
//
// Optional feature macro: HCSUB_FLAGS_EN adds the Ovf and Zero outputs,
// computed from the final difference in the output register stage.

module hc_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  output logic [15:0] Diff,
  output logic        Bout
`ifdef HCSUB_FLAGS_EN
  ,
  output logic        Ovf,
  output logic        Zero
`endif
);

  // Prefix-stage record: generate/propagate being combined in place, the raw
  // bitwise sum x = A ^ ~B kept for the final XOR, and the carry-in for bit 0.
  typedef struct packed {
    logic        v;
    logic        cin;
    logic [15:0] x;
    logic [15:0] g;
    logic [15:0] p;
`ifdef HCSUB_FLAGS_EN
    logic        a15;
    logic        b15;
`endif
  } pfx_t;

  // After the even fix-up the group propagates are no longer needed.
  typedef struct packed {
    logic        v;
    logic        cin;
    logic [15:0] x;
    logic [15:0] g;
`ifdef HCSUB_FLAGS_EN
    logic        a15;
    logic        b15;
`endif
  } fix_t;

  pfx_t s1_d, s1_q;
  pfx_t s2_d, s2_q;
  pfx_t s3_d, s3_q;
  pfx_t s4_d, s4_q;
  pfx_t s5_d, s5_q;
  fix_t s6_d, s6_q;

  logic [15:0] diff_d;
  logic        bout_d;
`ifdef HCSUB_FLAGS_EN
  logic        ovf_d;
  logic        zero_d;
`endif

  // s1: bitwise generate/propagate of A + ~B, carry-in folded into bit 0.
  always_comb begin
    s1_d      = '0;
    s1_d.v    = in_valid;
    s1_d.cin  = ~Bin;
    s1_d.x    = A ^ ~B;
    s1_d.g    = A & ~B;
    s1_d.p    = A ^ ~B;
    s1_d.g[0] = (A[0] & ~B[0]) | ((A[0] ^ ~B[0]) & ~Bin);
`ifdef HCSUB_FLAGS_EN
    s1_d.a15  = A[15];
    s1_d.b15  = B[15];
`endif
  end

  // s2: each odd position absorbs its even neighbour below (span of 2 bits).
  always_comb begin
    s2_d = s1_q;
    for (int i = 1; i < 16; i += 2) begin
      s2_d.g[i] = s1_q.g[i] | (s1_q.p[i] & s1_q.g[i-1]);
      s2_d.p[i] = s1_q.p[i] & s1_q.p[i-1];
    end
  end

  // s3: odd positions combine with the odd position 2 bits below (span 4).
  always_comb begin
    s3_d = s2_q;
    for (int i = 3; i < 16; i += 2) begin
      s3_d.g[i] = s2_q.g[i] | (s2_q.p[i] & s2_q.g[i-2]);
      s3_d.p[i] = s2_q.p[i] & s2_q.p[i-2];
    end
  end

  // s4: odd positions combine with the odd position 4 bits below (span 8).
  always_comb begin
    s4_d = s3_q;
    for (int i = 5; i < 16; i += 2) begin
      s4_d.g[i] = s3_q.g[i] | (s3_q.p[i] & s3_q.g[i-4]);
      s4_d.p[i] = s3_q.p[i] & s3_q.p[i-4];
    end
  end

  // s5: odd positions combine with the odd position 8 bits below; every odd
  // position now holds the full carry G[i:0].
  always_comb begin
    s5_d = s4_q;
    for (int i = 9; i < 16; i += 2) begin
      s5_d.g[i] = s4_q.g[i] | (s4_q.p[i] & s4_q.g[i-8]);
      s5_d.p[i] = s4_q.p[i] & s4_q.p[i-8];
    end
  end

  // s6: even positions pick up the finished carry of the odd bit below.
  // Bit 0 already holds G[0:0] because the carry-in was folded into it.
  always_comb begin
    s6_d     = '0;
    s6_d.v   = s5_q.v;
    s6_d.cin = s5_q.cin;
    s6_d.x   = s5_q.x;
    s6_d.g   = s5_q.g;
    for (int i = 2; i < 16; i += 2) begin
      s6_d.g[i] = s5_q.g[i] | (s5_q.p[i] & s5_q.g[i-1]);
    end
`ifdef HCSUB_FLAGS_EN
    s6_d.a15 = s5_q.a15;
    s6_d.b15 = s5_q.b15;
`endif
  end

  // Output stage: sum bit i uses the carry out of bit i-1 (cin for bit 0);
  // borrow-out is the inverted carry-out of bit 15.
  always_comb begin
    diff_d = s6_q.x ^ {s6_q.g[14:0], s6_q.cin};
    bout_d = ~s6_q.g[15];
`ifdef HCSUB_FLAGS_EN
    ovf_d  = (s6_q.a15 != s6_q.b15) & (diff_d[15] != s6_q.a15);
    zero_d = (diff_d == 16'h0000);
`endif
  end

  // Pipeline registers: all stages advance together on enabled edges; reset
  // clears every valid flag and the visible outputs regardless of en.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      s4_q      <= s4_d;
      s5_q      <= s5_d;
      s6_q      <= s6_d;
      out_valid <= s6_q.v;
      Diff      <= diff_d;
      Bout      <= bout_d;
`ifdef HCSUB_FLAGS_EN
      Ovf       <= ovf_d;
      Zero      <= zero_d;
`endif
    end
    if (rst) begin
      s1_q.v    <= 1'b0;
      s2_q.v    <= 1'b0;
      s3_q.v    <= 1'b0;
      s4_q.v    <= 1'b0;
      s5_q.v    <= 1'b0;
      s6_q.v    <= 1'b0;
      out_valid <= 1'b0;
      Diff      <= 16'h0000;
      Bout      <= 1'b0;
`ifdef HCSUB_FLAGS_EN
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_hc_subtractor.sv
// tb_hc_subtractor: randomized and directed stimulus for hc_subtractor with
// an arithmetic reference model, an expected queue filled on accepting edges
// and a monitor that pops and compares on every enabled output edge.
// Build with HCSUB_FLAGS_EN defined to also check Ovf/Zero.

module tb_hc_subtractor;

  localparam int EW = 51; // {acc_edge[31:0], zero, ovf, bout, diff[15:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic [15:0] Diff;
  logic        Bout;
`ifdef HCSUB_FLAGS_EN
  logic        Ovf;
  logic        Zero;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            en_cnt = 0;
  logic          last_en = 1'b0;
  logic          last_rst = 1'b1;
  logic          prev_ov = 1'b0;
  logic [15:0]   prev_diff = 16'h0000;
  logic          prev_bout = 1'b0;
`ifdef HCSUB_FLAGS_EN
  logic [1:0]    prev_flags = 2'b00;
`endif

  hc_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .Diff      (Diff),
    .Bout      (Bout)
`ifdef HCSUB_FLAGS_EN
    ,
    .Ovf       (Ovf),
    .Zero      (Zero)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned difference for Diff/Bout, signed
  // range check for Ovf.
  function automatic logic [EW-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic bi, input int acc);
    int          d;
    int          s;
    logic [15:0] df;
    logic        bo;
    logic        ov;
    logic        z;
    d  = int'(a) - int'(b) - int'(bi);
    bo = (d < 0);
    df = d[15:0];
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    ov = (s < -32768) || (s > 32767);
    z  = (df == 16'h0000);
    return {acc, z, ov, bo, df};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [15:0] a, input logic [15:0] b, input logic bi);
    @(negedge clk);
    rst      = r;
    en       = e;
    in_valid = v;
    A        = a;
    B        = b;
    Bin      = bi;
  endtask

  task automatic drive_rand(input logic e, input logic v);
    drive(1'b0, e, v, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // ---------------- scoreboard input side ----------------
  // On each rising edge: record what the edge did, queue accepted ops.
  initial begin
    forever begin
      @(posedge clk);
      last_rst = rst;
      last_en  = en;
      if (rst) begin
        exp_q.delete();
      end else if (en) begin
        if (in_valid) exp_q.push_back(model(A, B, Bin, en_cnt));
        en_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    int            lat;
    forever begin
      @(negedge clk);
      if (last_rst) begin
        chk("reset_outputs", {47'd0, out_valid, Diff}, 64'd0);
        chk("reset_bout", {63'd0, Bout}, 64'd0);
`ifdef HCSUB_FLAGS_EN
        chk("reset_flags", {62'd0, Zero, Ovf}, 64'd0);
`endif
      end else if (!last_en) begin
        chk("frozen", {46'd0, out_valid, Bout, Diff}, {46'd0, prev_ov, prev_bout, prev_diff});
`ifdef HCSUB_FLAGS_EN
        chk("frozen_flags", {62'd0, Zero, Ovf}, {62'd0, prev_flags});
`endif
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_output", {63'd0, out_valid}, 64'd0);
        end else begin
          e   = exp_q.pop_front();
          lat = en_cnt - 1 - int'(e[50:19]);
          chk("result", {15'd0, 32'(lat), Bout, Diff}, {15'd0, 32'd6, e[16], e[15:0]});
`ifdef HCSUB_FLAGS_EN
          chk("flags", {62'd0, Zero, Ovf}, {62'd0, e[18:17]});
`endif
        end
      end else if (exp_q.size() != 0) begin
        e   = exp_q[0];
        lat = en_cnt - 1 - int'(e[50:19]);
        if (lat >= 6) begin
          chk("missing_output", {63'd0, out_valid}, 64'd1);
          void'(exp_q.pop_front());
        end
      end
      prev_ov   = out_valid;
      prev_diff = Diff;
      prev_bout = Bout;
`ifdef HCSUB_FLAGS_EN
      prev_flags = {Zero, Ovf};
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0;

    // Reset with en both ways and junk valid ops that must be ignored.
    drive(1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h1111, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 16'h5555, 16'h2222, 1'b1);

    // Directed corner cases, back to back.
    drive(1'b0, 1'b1, 1'b1, 16'h1234, 16'h0234, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h8000, 16'h0000, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 16'h5555, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
    repeat (8) drive_rand(1'b1, 1'b0);

    // 20 back-to-back random operations.
    for (int i = 0; i < 20; i++) drive_rand(1'b1, 1'b1);

    // Stream with a 3-cycle stall in the middle; stalled inputs look valid.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) repeat (3) drive_rand(1'b0, 1'b1);
      drive_rand(1'b1, 1'b1);
    end

    // Random mix of stalls and gaps.
    for (int i = 0; i < 200; i++) begin
      drive_rand(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0));
    end
    repeat (8) drive_rand(1'b1, 1'b0);

    // Reset for one cycle with 4 operations in flight, then fresh ops.
    for (int i = 0; i < 4; i++) drive_rand(1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0);
    for (int i = 0; i < 5; i++) drive_rand(1'b1, 1'b1);

    // Drain with a bounded number of idle enabled cycles.
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      drive_rand(1'b1, 1'b0);
      guard++;
    end
    drive_rand(1'b1, 1'b0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
